// File: rtl/sbus_host_sequencer.sv
// Host-side sequencer for the strobe-based peripheral bus: runs one
// write-args / start / poll / read-results transaction per accepted command.
module sbus_host_sequencer #(
  parameter logic [15:0] ADDR_A1       = 16'h037F,
  parameter logic [15:0] ADDR_A2       = 16'h0388,
  parameter logic [15:0] ADDR_CTRL     = 16'h03A0,
  parameter logic [15:0] ADDR_RES      = 16'h0390,
  parameter logic [15:0] ADDR_CNT      = 16'h0398,
  parameter int unsigned STROBE_CYCLES = 1,
  parameter int unsigned POLL_GAP      = 2,
  parameter int unsigned POLL_LIMIT    = 16
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [23:0] cmd_a1,
  input  logic [23:0] cmd_a2,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [23:0] rsp_ones,
  output logic        rsp_timeout,
  output logic [15:0] saddress,
  output logic        srd,
  output logic        swr,
  output logic [31:0] sdata_out,
  input  logic [31:0] sdata_in,
  output logic [15:0] txn_count
);

  typedef enum logic [3:0] {
    StIdle, StWrA1, StWrA2, StWrStart, StPoll, StPollWait,
    StRdRes0, StRdRes1, StRdCnt, StResp
  } state_e;

  typedef enum logic [1:0] {PhSetup, PhStrobe, PhHold} phase_e;

  state_e      state_q, state_d;
  phase_e      phase_q, phase_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] poll_q, poll_d;
  logic [23:0] a2_q, a2_d;
  logic [15:0] saddress_q, saddress_d;
  logic [31:0] sdata_q, sdata_d;
  logic        srd_q, srd_d, swr_q, swr_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] result_q, result_d;
  logic [23:0] ones_q, ones_d;
  logic        timeout_q, timeout_d;
  logic [15:0] txn_q, txn_d;
  logic        ready_q, ready_d;

  logic        is_acc, is_wr, acc_done, start_acc;
  logic [15:0] acc_addr;
  logic [31:0] acc_data;

  assign is_acc = state_q inside {StWrA1, StWrA2, StWrStart, StPoll, StRdRes0, StRdRes1, StRdCnt};
  assign is_wr  = state_q inside {StWrA1, StWrA2, StWrStart};

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    cnt_d       = cnt_q;
    poll_d      = poll_q;
    a2_d        = a2_q;
    saddress_d  = saddress_q;
    sdata_d     = sdata_q;
    srd_d       = srd_q;
    swr_d       = swr_q;
    rsp_valid_d = rsp_valid_q;
    result_d    = result_q;
    ones_d      = ones_q;
    timeout_d   = timeout_q;
    txn_d       = txn_q;
    acc_done    = 1'b0;
    start_acc   = 1'b0;
    acc_addr    = saddress_q;
    acc_data    = 32'd0;

    // Shared SETUP / STROBE / HOLD sub-sequence for every bus access.
    if (is_acc) begin
      unique case (phase_q)
        PhSetup: begin
          phase_d = PhStrobe;
          cnt_d   = 8'd0;
          swr_d   = is_wr;
          srd_d   = ~is_wr;
        end
        PhStrobe: begin
          if (cnt_q == 8'(STROBE_CYCLES - 1)) begin
            phase_d = PhHold;
            swr_d   = 1'b0;
            srd_d   = 1'b0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        PhHold:  acc_done = 1'b1;
        default: phase_d = PhSetup;
      endcase
    end

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          a2_d      = cmd_a2;
          result_d  = 32'd0;
          ones_d    = 24'd0;
          timeout_d = 1'b0;
          state_d   = StWrA1;
          start_acc = 1'b1;
          acc_addr  = ADDR_A1;
          acc_data  = {8'd0, cmd_a1};
        end
      end
      StWrA1: if (acc_done) begin
        state_d   = StWrA2;
        start_acc = 1'b1;
        acc_addr  = ADDR_A2;
        acc_data  = {8'd0, a2_q};
      end
      StWrA2: if (acc_done) begin
        state_d   = StWrStart;
        start_acc = 1'b1;
        acc_addr  = ADDR_CTRL;
      end
      StWrStart: if (acc_done) begin
        state_d   = StPoll;
        poll_d    = 16'd0;
        start_acc = 1'b1;
        acc_addr  = ADDR_CTRL;
      end
      StPoll: if (acc_done) begin
        poll_d = poll_q + 16'd1;
        if (!sdata_in[1]) begin
          state_d   = StRdRes0;
          start_acc = 1'b1;
          acc_addr  = ADDR_RES;
        end else if (32'(poll_q) + 32'd1 >= POLL_LIMIT) begin
          timeout_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = StResp;
        end else if (POLL_GAP == 0) begin
          start_acc = 1'b1;
          acc_addr  = ADDR_CTRL;
        end else begin
          state_d = StPollWait;
          cnt_d   = 8'd0;
        end
      end
      StPollWait: begin
        if (cnt_q == 8'(POLL_GAP - 1)) begin
          state_d   = StPoll;
          start_acc = 1'b1;
          acc_addr  = ADDR_CTRL;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      // First result read returns the stale value; only the second is kept.
      StRdRes0: if (acc_done) begin
        state_d   = StRdRes1;
        start_acc = 1'b1;
        acc_addr  = ADDR_RES;
      end
      StRdRes1: if (acc_done) begin
        result_d  = sdata_in;
        state_d   = StRdCnt;
        start_acc = 1'b1;
        acc_addr  = ADDR_CNT;
      end
      StRdCnt: if (acc_done) begin
        ones_d      = sdata_in[23:0];
        rsp_valid_d = 1'b1;
        state_d     = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          txn_d       = txn_q + 16'd1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (start_acc) begin
      phase_d    = PhSetup;
      saddress_d = acc_addr;
      sdata_d    = acc_data;
    end

    ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= StIdle;
      phase_q     <= PhSetup;
      cnt_q       <= 8'd0;
      poll_q      <= 16'd0;
      a2_q        <= 24'd0;
      saddress_q  <= 16'd0;
      sdata_q     <= 32'd0;
      srd_q       <= 1'b0;
      swr_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      result_q    <= 32'd0;
      ones_q      <= 24'd0;
      timeout_q   <= 1'b0;
      txn_q       <= 16'd0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      poll_q      <= poll_d;
      a2_q        <= a2_d;
      saddress_q  <= saddress_d;
      sdata_q     <= sdata_d;
      srd_q       <= srd_d;
      swr_q       <= swr_d;
      rsp_valid_q <= rsp_valid_d;
      result_q    <= result_d;
      ones_q      <= ones_d;
      timeout_q   <= timeout_d;
      txn_q       <= txn_d;
      ready_q     <= ready_d;
    end
  end

  assign cmd_ready   = ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_result  = result_q;
  assign rsp_ones    = ones_q;
  assign rsp_timeout = timeout_q;
  assign saddress    = saddress_q;
  assign srd         = srd_q;
  assign swr         = swr_q;
  assign sdata_out   = sdata_q;
  assign txn_count   = txn_q;

endmodule
